sync_fifo_buf: RTL and testbench
================================

SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 Parameter DATASIZE, default 8, data word width in bits.
REQ-002 Parameter ADDRSIZE, default 4, address width; DEPTH = 1<<ADDRSIZE words.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, occupancy at or above which wafull asserts.
REQ-004 Parameter AEMPTY_LVL, default 2, occupancy at or below which raempty asserts.
REQ-005 wclk  input  1  the only clock; all sequential logic is on its rising edge.
REQ-006 wrst_n  input  1  asynchronous, active-low reset.
REQ-007 winc  input  1  write request.
REQ-008 wdata  input  DATASIZE  write data.
REQ-009 rinc  input  1  read request.
REQ-010 rdata  output  DATASIZE  registered read data.
REQ-011 rvalid  output  1  rdata holds newly popped word this cycle.
REQ-012 wfull  output  1  occupancy == DEPTH.
REQ-013 rempty  output  1  occupancy == 0.
REQ-014 wafull  output  1  occupancy >= AFULL_LVL.
REQ-015 raempty  output  1  occupancy <= AEMPTY_LVL.
REQ-016 count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
REQ-017 ovf_err  output  1  sticky: write attempted while full.
REQ-018 udf_err  output  1  sticky: read attempted while empty.

Function
REQ-019 Storage SHALL be a DEPTH x DATASIZE array, not reset, written only on an accepted write.
REQ-020 wptr and rptr SHALL each be ADDRSIZE+1 bits; the low ADDRSIZE bits address memory; the MSB toggles on wrap from DEPTH-1 to 0.
REQ-021 Write SHALL be accepted iff winc=1 and wfull=0 at the edge; the word is stored at wptr[ADDRSIZE-1:0] and wptr increments by 1.
REQ-022 Read SHALL be accepted iff rinc=1 and rempty=0 at the edge; rdata <= MEM[rptr[ADDRSIZE-1:0]], rptr increments, rvalid=1 the following cycle.
REQ-023 Read latency SHALL be exactly one cycle from accepted rinc to rvalid/rdata.
REQ-024 rvalid SHALL be 0 in any cycle following a non-accepted read; rdata SHALL hold its last value when no read is accepted.
REQ-025 count SHALL be a registered counter: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
REQ-026 wfull, rempty, wafull, raempty SHALL be registered, consistent with count in the same cycle (no lag).
REQ-027 Full + winc + rinc same edge: read accepted, write rejected, ovf_err set, count -> DEPTH-1.
REQ-028 Empty + winc + rinc same edge: write accepted, read rejected, udf_err set, count -> 1; no read-through of wdata.
REQ-029 Non-full, non-empty + winc + rinc: both accepted, count unchanged.
REQ-030 ovf_err SHALL set on winc=1 while wfull=1 and remain 1 until reset; udf_err likewise for rinc=1 while rempty=1.
REQ-031 Rejected requests SHALL NOT alter pointers, memory, count or rdata.
REQ-032 Pointer wrap SHALL be seamless: data order preserved across any number of wraps.

Reset
REQ-033 On wrst_n=0, immediately and independent of wclk: wptr=0, rptr=0, count=0, rdata=0, rvalid=0, wfull=0, rempty=1, wafull=(AFULL_LVL==0), raempty=1, ovf_err=0, udf_err=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored data logically; memory contents need not be cleared.
REQ-035 Requests SHALL be ignored on the first edge where wrst_n is sampled low; operation resumes on the first edge after deassertion.

Verification
REQ-036 Reset, then write 0x01..0x10 (16 writes, defaults) -> wfull=1 after 16th, count=16, wafull=1 from count=14.
REQ-037 Read 16 words -> rdata 0x01..0x10 in order, each with rvalid one cycle after rinc; rempty=1, raempty=1 at end.
REQ-038 At full, winc+rinc same edge -> oldest word returned, count=15, ovf_err=1 and stays 1.
REQ-039 At empty, winc=1 wdata=0xA5 with rinc=1 -> udf_err=1, rvalid=0 next cycle, count=1; next rinc returns 0xA5.
REQ-040 Stream 40 words with continuous simultaneous read/write at count=8 -> order preserved across two pointer wraps, count stays 8.
REQ-041 Assert wrst_n=0 mid-cycle with count=5 -> all outputs reach reset values before next wclk edge; subsequent read shows rempty=1, udf_err=1.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with a registered read port, registered occupancy flags
// and sticky overflow/underflow error bits.
module sync_fifo_buf #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                wafull,
  output logic                raempty,
  output logic [ADDRSIZE:0]   count,
  output logic                ovf_err,
  output logic                udf_err
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDRSIZE:0]   count_q, count_d;
  logic [DATASIZE-1:0] rdata_q;
  logic                rvalid_q;
  logic                wfull_q, wfull_d, rempty_q, rempty_d;
  logic                wafull_q, wafull_d, raempty_q, raempty_d;
  logic                ovf_q, udf_q;
  logic                wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still drains on a
  // simultaneous read/write and an empty one still fills.
  assign wr_acc = winc && !wfull_q;
  assign rd_acc = rinc && !rempty_q;

  always_comb begin
    wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    // Full/empty come from the wrap-bit pointer compare; the programmable
    // levels from the occupancy counter. Both track the same next state.
    wfull_d   = (wptr_d == {~rptr_d[ADDRSIZE], rptr_d[ADDRSIZE-1:0]});
    rempty_d  = (wptr_d == rptr_d);
    wafull_d  = (int'(count_d) >= AFULL_LVL);
    raempty_d = (int'(count_d) <= AEMPTY_LVL);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wfull_q   <= 1'b0;
      rempty_q  <= 1'b1;
      wafull_q  <= (AFULL_LVL <= 0);
      raempty_q <= (AEMPTY_LVL >= 0);
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rvalid_q  <= rd_acc;
      if (rd_acc) rdata_q <= mem_q[rptr_q[ADDRSIZE-1:0]];
      wfull_q   <= wfull_d;
      rempty_q  <= rempty_d;
      wafull_q  <= wafull_d;
      raempty_q <= raempty_d;
      if (winc && wfull_q)  ovf_q <= 1'b1;
      if (rinc && rempty_q) udf_q <= 1'b1;
    end
  end

  // Storage is intentionally unreset; reset only rewinds the pointers.
  always_ff @(posedge wclk) begin
    if (wr_acc) mem_q[wptr_q[ADDRSIZE-1:0]] <= wdata;
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign wfull   = wfull_q;
  assign rempty  = rempty_q;
  assign wafull  = wafull_q;
  assign raempty = raempty_q;
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Directed bench for sync_fifo_buf: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_sync_fifo_buf;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 14;
  localparam int AEMPTY = 2;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0, rinc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, rempty, wafull, raempty, ovf_err, udf_err;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  sync_fifo_buf #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .wafull(wafull), .raempty(raempty), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 wclk = ~wclk;

  // Reference model: a plain queue of stored words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mq.delete();
      m_rdata = '0;
      m_rvalid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit full  = (mq.size() == DEPTH);
      automatic bit empty = (mq.size() == 0);
      automatic bit wa = winc && !full;
      automatic bit ra = rinc && !empty;
      if (winc && full) m_ovf = 1'b1;
      if (rinc && empty) m_udf = 1'b1;
      m_rvalid = ra;
      if (ra) m_rdata = mq.pop_front();
      if (wa) mq.push_back(wdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_rdata",   32'(rdata),   32'(m_rdata));
    chk("m_rvalid",  32'(rvalid),  32'(m_rvalid));
    chk("m_count",   32'(count),   mq.size());
    chk("m_wfull",   32'(wfull),   32'(mq.size() == DEPTH));
    chk("m_rempty",  32'(rempty),  32'(mq.size() == 0));
    chk("m_wafull",  32'(wafull),  32'(mq.size() >= AFULL));
    chk("m_raempty", 32'(raempty), 32'(mq.size() <= AEMPTY));
    chk("m_ovf",     32'(ovf_err), 32'(m_ovf));
    chk("m_udf",     32'(udf_err), 32'(m_udf));
  endtask

  always @(negedge wclk) chk_model();

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    winc = w; wdata = d; rinc = r;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  initial begin
    @(negedge wclk);
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_raempty", 32'(raempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    wrst_n = 1'b1;

    // Fill with 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0);
      chk("fill_count", 32'(count), i + 1);
      chk("fill_wafull", 32'(wafull), 32'(i + 1 >= 14));
    end
    chk("fill_wfull", 32'(wfull), 1);

    // Drain, one-cycle latency each
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_rvalid", 32'(rvalid), 1);
      chk("drain_rdata", 32'(rdata), i + 1);
    end
    chk("drain_rempty", 32'(rempty), 1);
    chk("drain_raempty", 32'(raempty), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_rvalid", 32'(rvalid), 0);
    chk("idle_rdata_hold", 32'(rdata), 32'h10);

    // Full + simultaneous write/read
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full_both_rdata", 32'(rdata), 32'h20);
    chk("full_both_count", 32'(count), 15);
    chk("full_both_ovf", 32'(ovf_err), 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(ovf_err), 1);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("full_drain_rdata", 32'(rdata), 32'h21 + i);
    end

    // Empty + simultaneous write/read
    cyc(1'b1, 8'hA5, 1'b1);
    chk("empty_both_udf", 32'(udf_err), 1);
    chk("empty_both_rvalid", 32'(rvalid), 0);
    chk("empty_both_count", 32'(count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("a5_rdata", 32'(rdata), 32'hA5);
    chk("a5_rvalid", 32'(rvalid), 1);

    // Streaming across pointer wraps at occupancy 8
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h48 + i), 1'b1);
      chk("stream_rdata", 32'(rdata), 32'h40 + i);
      chk("stream_count", 32'(count), 8);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("tail_rdata", 32'(rdata), 32'h68 + i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(count), 5);

    // Asynchronous reset mid-cycle, with a write held during reset
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_rempty", 32'(rempty), 1);
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_rdata", 32'(rdata), 0);
    chk("arst_ovf", 32'(ovf_err), 0);
    chk("arst_udf", 32'(udf_err), 0);
    winc = 1'b1; wdata = 8'h77;
    @(posedge wclk);
    @(negedge wclk);
    chk("in_rst_count", 32'(count), 0);
    wrst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_udf", 32'(udf_err), 1);
    chk("post_rst_rempty", 32'(rempty), 1);
    chk("post_rst_rvalid", 32'(rvalid), 0);
    cyc(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
